wb_stage_reg: RTL and testbench
===============================

# wb_stage_reg

Parametrised MEM/WB pipeline register for the multi-issue core. It sits between the memory-access stage and register-file write-back and carries LANES parallel GPR write ports plus per-lane HI/LO payloads. It implements the stall-vector hold/bubble protocol, adds an exception flush, and resolves same-cycle write conflicts between lanes. An optional block of performance counters is included.

## Interface
Parameters:
- DATA_W, 32, GPR/HI/LO data width
- ADDR_W, 5, GPR address width
- LANES, 2, issue lanes (1..4); lane 0 is oldest
- STALL_W, 6, width of the stall vector
- STAGE, 4, index of this stage's bit in the stall vector; STAGE+1 < STALL_W

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  STALL_W  per-stage stall vector, 1 = Stop
- flush  in  1  exception/eret flush of this stage
- mem_valid  in  LANES  lane carries a live instruction
- mem_wd  in  LANES×ADDR_W  destination GPR
- mem_wreg  in  LANES  GPR write enable
- mem_wdata  in  LANES×DATA_W  GPR write data
- mem_hi, mem_lo  in  LANES×DATA_W  HI/LO write data
- mem_whilo  in  LANES  HI/LO write enable
- wb_wd  out  LANES×ADDR_W  registered destination
- wb_wreg  out  LANES  registered, conflict-resolved write enable
- wb_wdata  out  LANES×DATA_W
- wb_hi, wb_lo  out  LANES×DATA_W
- wb_whilo  out  LANES
- perf_bubble_cnt, perf_hold_cnt  out  32  only with WB_PERF_EN

## Operation
- Update priority on each rising clk edge: rst > flush > bubble > hold > advance.
- rst or flush: all outputs cleared (wd=0, wreg=0, wdata/hi/lo=0, whilo=0).
- bubble: stall[STAGE]=1 and stall[STAGE+1]=0. All lanes are loaded with the cleared value.
- hold: stall[STAGE]=1 and stall[STAGE+1]=1. All outputs keep their current values.
- advance: stall[STAGE]=0. Each lane is loaded from its inputs after the following qualifications:
  - An invalid lane (mem_valid=0) is loaded as the cleared value.
  - wreg is forced to 0 when mem_wd==0 ($zero is never written). wd and wdata are still captured.
  - GPR conflict: if lane i<j are both valid, both have wreg=1 and the same nonzero wd, then lane i's wb_wreg is 0. The youngest writer wins. This is evaluated across all lane pairs.
  - HI/LO conflict: if multiple valid lanes assert whilo, only the highest-index one keeps wb_whilo=1.
- Cleared or killed lanes keep their payload fields at the cleared value. Conflict-killed lanes keep their payload, with only the enable dropped.
- stall bits other than STAGE and STAGE+1 are ignored.

## Timing
- Latency: 1 cycle, input to output, on advance.
- Outputs are purely registered. There is no combinational path from any input to any output.
- Reset value of every output is 0, including the perf counters.
- A flush on the same edge as a stall wins: the outputs are cleared and do not hold.
- If rst is released mid-stall, the first post-reset edge follows the normal priority.
- Holds of arbitrary length are allowed. The outputs stay bit-stable for the whole hold.

## Configuration
- WB_PERF_EN defined:
  - perf_bubble_cnt increments on every bubble edge.
  - perf_hold_cnt increments on every hold edge.
  - Both counters are 32-bit, saturate at 0xFFFFFFFF, and clear on rst only (flush does not clear them).
- WB_PERF_EN undefined: the ports and counters are absent, and there is no area cost.

## Structure
- The shared package cpu_pkg provides:
  - Constants: STOP=1, NOSTOP=0, NOP_REG_ADDR=0, ZERO_WORD=0.
  - The typedef wb_lane_t {wd, wreg, wdata, hi, lo, whilo}, parametrised by DATA_W/ADDR_W through a package-level default.
- One sub-module, wb_conflict_resolve: combinational, LANES-wide. It produces the qualified wreg/whilo vectors from the valid/wd/wreg/whilo inputs. The top level holds the registers, the priority logic and the optional counters.

## Test plan
- Reset: assert rst with all inputs nonzero -> every output 0 on the next edge; perf counters 0.
- Advance/bubble/hold: LANES=2, lane0 {wd=3, wdata=0x11111111}, lane1 {wd=4, wdata=0x22222222}, stall=0 -> both written next edge.
  - stall=6'b010000 -> both lanes cleared.
  - stall=6'b110000 for 5 cycles -> outputs unchanged; perf_hold_cnt=5.
- GPR conflict: both lanes wd=7, wreg=1 -> wb_wreg=2'b10, with lane0 wdata still captured.
  - Repeat with wd=0 on both lanes -> wb_wreg=2'b00.
- HI/LO conflict and validity: both lanes whilo=1 -> wb_whilo=2'b10.
  - lane1 mem_valid=0 -> lane1 outputs all 0, lane0 wb_whilo=1.
- Flush vs. stall: flush=1 together with stall=6'b110000 -> outputs cleared; next cycle with flush=0 -> outputs hold.
- Saturation (WB_PERF_EN): force perf_bubble_cnt to 0xFFFFFFFE, apply 3 bubbles -> reads 0xFFFFFFFF; rst -> 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core definitions: stall encoding, reset constants, the write-back lane
// record and the MEM/WB update-priority decision.
package cpu_pkg;

   localparam logic        STOP         = 1'b1;
   localparam logic        NOSTOP       = 1'b0;
   localparam int          NOP_REG_ADDR = 0;
   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 5;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] wd;
      logic                 wreg;
      logic [WB_DATA_W-1:0] wdata;
      logic [WB_DATA_W-1:0] hi;
      logic [WB_DATA_W-1:0] lo;
      logic                 whilo;
   } wb_lane_t;

   typedef enum logic [2:0] {
      UPD_RESET,
      UPD_FLUSH,
      UPD_BUBBLE,
      UPD_HOLD,
      UPD_ADVANCE
   } wb_upd_e;

   // Priority: reset > flush > bubble > hold > advance.
   function automatic wb_upd_e wb_update_sel(input logic rst_req,
                                             input logic flush_req,
                                             input logic this_stall,
                                             input logic next_stall);
      if (rst_req)
         return UPD_RESET;
      if (flush_req)
         return UPD_FLUSH;
      if (this_stall == STOP)
         return (next_stall == NOSTOP) ? UPD_BUBBLE : UPD_HOLD;
      return UPD_ADVANCE;
   endfunction

endpackage

// File: rtl/wb_conflict_resolve.sv
// Qualifies per-lane GPR and HI/LO write enables: drops $zero writes and keeps
// only the youngest writer when several lanes target the same resource.
module wb_conflict_resolve
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int LANES  = 2
) (
   input  logic [LANES-1:0]        valid,
   input  logic [LANES*ADDR_W-1:0] wd,
   input  logic [LANES-1:0]        wreg,
   input  logic [LANES-1:0]        whilo,
   output logic [LANES-1:0]        wreg_ok,
   output logic [LANES-1:0]        whilo_ok
);

   logic [LANES-1:0] gpr_wr;
   logic [LANES-1:0] hilo_wr;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         gpr_wr[i]  = valid[i] & wreg[i] &
                      (wd[i*ADDR_W +: ADDR_W] != ADDR_W'(NOP_REG_ADDR));
         hilo_wr[i] = valid[i] & whilo[i];
      end
   end

   // Lane index grows with age-order youth, so any later live writer kills an earlier one.
   always_comb begin
      // NOTE: whole-vector defaults first so every bit is assigned on every path and no latch is inferred.
      wreg_ok  = gpr_wr;
      whilo_ok = hilo_wr;
      for (int i = 0; i < LANES; i++) begin
         for (int j = i + 1; j < LANES; j++) begin
            if (gpr_wr[j] && (wd[j*ADDR_W +: ADDR_W] == wd[i*ADDR_W +: ADDR_W]))
               wreg_ok[i] = 1'b0;
            if (hilo_wr[j])
               whilo_ok[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register with stall hold/bubble, flush and lane write-conflict
// resolution. Optional performance counters are built when WB_PERF_EN is defined.
module wb_stage_reg
   import cpu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int LANES   = 2,
   parameter int STALL_W = 6,
   parameter int STAGE   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [STALL_W-1:0]      stall,
   input  logic                    flush,
   input  logic [LANES-1:0]        mem_valid,
   input  logic [LANES*ADDR_W-1:0] mem_wd,
   input  logic [LANES-1:0]        mem_wreg,
   input  logic [LANES*DATA_W-1:0] mem_wdata,
   input  logic [LANES*DATA_W-1:0] mem_hi,
   input  logic [LANES*DATA_W-1:0] mem_lo,
   input  logic [LANES-1:0]        mem_whilo,
   output logic [LANES*ADDR_W-1:0] wb_wd,
   output logic [LANES-1:0]        wb_wreg,
   output logic [LANES*DATA_W-1:0] wb_wdata,
   output logic [LANES*DATA_W-1:0] wb_hi,
   output logic [LANES*DATA_W-1:0] wb_lo,
   output logic [LANES-1:0]        wb_whilo
`ifdef WB_PERF_EN
   ,
   output logic [31:0]             perf_bubble_cnt,
   output logic [31:0]             perf_hold_cnt
`endif
);

   if (LANES < 1 || LANES > 4) begin : g_bad_lanes
      $error("wb_stage_reg: LANES must be in 1..4");
   end
   if (STAGE + 1 >= STALL_W) begin : g_bad_stage
      $error("wb_stage_reg: STAGE+1 must index into the stall vector");
   end

   typedef struct packed {
      logic [ADDR_W-1:0] wd;
      logic              wreg;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
      logic              whilo;
   } lane_t;

   localparam lane_t LANE_CLEAR = '0;

   lane_t            lane_q [LANES];
   lane_t            lane_d [LANES];
   logic [LANES-1:0] wreg_ok;
   logic [LANES-1:0] whilo_ok;
   wb_upd_e          upd;

   // Only this stage's bit and the next stage's bit matter.
   logic stall_unused;
   assign stall_unused = ^stall;

   assign upd = wb_update_sel(rst, flush, stall[STAGE], stall[STAGE+1]);

   wb_conflict_resolve #(
      .ADDR_W (ADDR_W),
      .LANES  (LANES)
   ) u_conflict (
      .valid    (mem_valid),
      .wd       (mem_wd),
      .wreg     (mem_wreg),
      .whilo    (mem_whilo),
      .wreg_ok  (wreg_ok),
      .whilo_ok (whilo_ok)
   );

   // Dead lanes carry an all-zero payload; conflict-killed lanes keep theirs.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         lane_d[i] = LANE_CLEAR;
         if (mem_valid[i]) begin
            lane_d[i].wd    = mem_wd[i*ADDR_W +: ADDR_W];
            lane_d[i].wreg  = wreg_ok[i];
            lane_d[i].wdata = mem_wdata[i*DATA_W +: DATA_W];
            lane_d[i].hi    = mem_hi[i*DATA_W +: DATA_W];
            lane_d[i].lo    = mem_lo[i*DATA_W +: DATA_W];
            lane_d[i].whilo = whilo_ok[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
      unique case (upd)
         UPD_RESET, UPD_FLUSH, UPD_BUBBLE: begin
            for (int i = 0; i < LANES; i++)
               lane_q[i] <= LANE_CLEAR;
         end
         UPD_ADVANCE: begin
            for (int i = 0; i < LANES; i++)
               lane_q[i] <= lane_d[i];
         end
         default: ;
      endcase
   end

   for (genvar g = 0; g < LANES; g++) begin : g_out
      assign wb_wd[g*ADDR_W +: ADDR_W]    = lane_q[g].wd;
      assign wb_wreg[g]                   = lane_q[g].wreg;
      assign wb_wdata[g*DATA_W +: DATA_W] = lane_q[g].wdata;
      assign wb_hi[g*DATA_W +: DATA_W]    = lane_q[g].hi;
      assign wb_lo[g*DATA_W +: DATA_W]    = lane_q[g].lo;
      assign wb_whilo[g]                  = lane_q[g].whilo;
   end

`ifdef WB_PERF_EN
   logic [31:0] bubble_cnt_q;
   logic [31:0] hold_cnt_q;

   // Saturating counters; flush leaves them alone, only rst clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt_q <= '0;
         hold_cnt_q   <= '0;
      end else begin
         if (upd == UPD_BUBBLE && bubble_cnt_q != 32'hFFFF_FFFF)
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
         if (upd == UPD_HOLD && hold_cnt_q != 32'hFFFF_FFFF)
            hold_cnt_q <= hold_cnt_q + 32'd1;
      end
   end

   assign perf_bubble_cnt = bubble_cnt_q;
   assign perf_hold_cnt   = hold_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage_reg.sv
// Self-checking bench for wb_stage_reg: directed scenarios plus randomized traffic
// against a rule-level model of the MEM/WB register. Honours WB_PERF_EN.
module tb_wb_stage_reg;
   import cpu_pkg::*;

   localparam int L     = 2;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int SW    = 6;
   localparam int BUS_W = L * (AW + 1 + 3*DW + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic [SW-1:0]   stall;
   logic            flush;
   logic [L-1:0]    mem_valid;
   logic [L*AW-1:0] mem_wd;
   logic [L-1:0]    mem_wreg;
   logic [L*DW-1:0] mem_wdata;
   logic [L*DW-1:0] mem_hi;
   logic [L*DW-1:0] mem_lo;
   logic [L-1:0]    mem_whilo;
   logic [L*AW-1:0] wb_wd;
   logic [L-1:0]    wb_wreg;
   logic [L*DW-1:0] wb_wdata;
   logic [L*DW-1:0] wb_hi;
   logic [L*DW-1:0] wb_lo;
   logic [L-1:0]    wb_whilo;
`ifdef WB_PERF_EN
   logic [31:0]     perf_bubble_cnt;
   logic [31:0]     perf_hold_cnt;
`endif

   logic [BUS_W-1:0] obs;
   assign obs = {wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo};

   int checks = 0;
   int errors = 0;

   wb_stage_reg #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .LANES   (L),
      .STALL_W (SW),
      .STAGE   (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .flush     (flush),
      .mem_valid (mem_valid),
      .mem_wd    (mem_wd),
      .mem_wreg  (mem_wreg),
      .mem_wdata (mem_wdata),
      .mem_hi    (mem_hi),
      .mem_lo    (mem_lo),
      .mem_whilo (mem_whilo),
      .wb_wd     (wb_wd),
      .wb_wreg   (wb_wreg),
      .wb_wdata  (wb_wdata),
      .wb_hi     (wb_hi),
      .wb_lo     (wb_lo),
      .wb_whilo  (wb_whilo)
`ifdef WB_PERF_EN
      ,
      .perf_bubble_cnt (perf_bubble_cnt),
      .perf_hold_cnt   (perf_hold_cnt)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   wb_lane_t    m [L];
   logic [31:0] m_bubble = 32'd0;
   logic [31:0] m_hold   = 32'd0;

   // Next register contents from the architectural rules applied to the current inputs.
   task automatic model_step();
      wb_lane_t nxt [L];
      bit       claimed [32];
      bit       hilo_taken;
      logic [AW-1:0] a;
      for (int i = 0; i < L; i++) nxt[i] = m[i];
      if (rst) begin
         for (int i = 0; i < L; i++) nxt[i] = '0;
         m_bubble = 32'd0;
         m_hold   = 32'd0;
      end else if (flush) begin
         for (int i = 0; i < L; i++) nxt[i] = '0;
      end else if (stall[4] && !stall[5]) begin
         for (int i = 0; i < L; i++) nxt[i] = '0;
         if (m_bubble != 32'hFFFF_FFFF) m_bubble = m_bubble + 1;
      end else if (stall[4]) begin
         if (m_hold != 32'hFFFF_FFFF) m_hold = m_hold + 1;
      end else begin
         for (int k = 0; k < 32; k++) claimed[k] = 1'b0;
         hilo_taken = 1'b0;
         // Walk youngest to oldest: the first claimant of a register or of HI/LO wins.
         for (int i = L - 1; i >= 0; i--) begin
            nxt[i] = '0;
            if (mem_valid[i]) begin
               a = mem_wd[i*AW +: AW];
               nxt[i].wd    = a;
               nxt[i].wdata = mem_wdata[i*DW +: DW];
               nxt[i].hi    = mem_hi[i*DW +: DW];
               nxt[i].lo    = mem_lo[i*DW +: DW];
               if (mem_wreg[i] && a != 0) begin
                  nxt[i].wreg = !claimed[a];
                  claimed[a]  = 1'b1;
               end
               if (mem_whilo[i]) begin
                  nxt[i].whilo = !hilo_taken;
                  hilo_taken   = 1'b1;
               end
            end
         end
      end
      for (int i = 0; i < L; i++) m[i] = nxt[i];
   endtask

   function automatic logic [BUS_W-1:0] exp_bus();
      logic [L*AW-1:0] wd;
      logic [L-1:0]    wreg, whilo;
      logic [L*DW-1:0] wdata, hi, lo;
      for (int i = 0; i < L; i++) begin
         wd[i*AW +: AW]    = m[i].wd;
         wreg[i]           = m[i].wreg;
         wdata[i*DW +: DW] = m[i].wdata;
         hi[i*DW +: DW]    = m[i].hi;
         lo[i*DW +: DW]    = m[i].lo;
         whilo[i]          = m[i].whilo;
      end
      return {wd, wreg, wdata, hi, lo, whilo};
   endfunction

   // One clock: model consumes the pre-edge inputs, outputs are sampled 1 unit after the edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs(input int wd_max);
      mem_valid = L'($urandom);
      mem_wreg  = L'($urandom);
      mem_whilo = L'($urandom);
      for (int i = 0; i < L; i++) begin
         mem_wd[i*AW +: AW]    = AW'($urandom_range(wd_max, 0));
         mem_wdata[i*DW +: DW] = $urandom;
         mem_hi[i*DW +: DW]    = $urandom;
         mem_lo[i*DW +: DW]    = $urandom;
      end
   endtask

   task automatic set_lanes(input logic [AW-1:0] wd0, input logic [AW-1:0] wd1,
                            input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      mem_valid = 2'b11;
      mem_wreg  = 2'b11;
      mem_whilo = 2'b00;
      mem_wd    = {wd1, wd0};
      mem_wdata = {d1, d0};
      mem_hi    = {~d1, ~d0};
      mem_lo    = {d1 ^ 32'h5A5A_5A5A, d0 ^ 32'hA5A5_A5A5};
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst       = 1'b1;
      flush     = 1'b1;
      stall     = '1;
      mem_valid = '1;
      mem_wreg  = '1;
      mem_whilo = '1;
      mem_wd    = {5'd9, 5'd3};
      mem_wdata = {32'hDEAD_BEEF, 32'hCAFE_F00D};
      mem_hi    = {32'h1234_5678, 32'h9ABC_DEF0};
      mem_lo    = {32'h0F0F_0F0F, 32'hF0F0_F0F0};
      tick();
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", obs);
      end
`ifdef WB_PERF_EN
      checks++;
      if (perf_bubble_cnt !== 32'd0 || perf_hold_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_perf: got bubble=%h hold=%h want 0/0", perf_bubble_cnt, perf_hold_cnt);
      end
`endif
      // Release reset while the stage is held: cleared contents must persist.
      rst   = 1'b0;
      flush = 1'b0;
      stall = 6'b110000;
      tick();
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_release_hold: got %h want 0", obs);
      end
   endtask

   task automatic test_advance_bubble_hold();
      logic [BUS_W-1:0] held;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      stall = 6'b000000;
      set_lanes(5'd3, 5'd4, 32'h1111_1111, 32'h2222_2222);
      tick();
      checks++;
      if (wb_wreg !== 2'b11 || wb_wd !== {5'd4, 5'd3} || wb_wdata !== {32'h2222_2222, 32'h1111_1111}) begin
         errors++;
         $display("FAIL advance_direct: got wreg=%b wd=%h wdata=%h want 11/083/2222222211111111",
                  wb_wreg, wb_wd, wb_wdata);
      end
      checks++;
      if (obs !== exp_bus()) begin
         errors++;
         $display("FAIL advance_model: got %h want %h", obs, exp_bus());
      end
      stall = 6'b010000;
      tick();
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL bubble_clear: got %h want 0", obs);
      end
      stall = 6'b000000;
      tick();
      held = exp_bus();
      stall = 6'b110000;
      for (int c = 0; c < 5; c++) begin
         rand_inputs(31);
         tick();
         checks++;
         if (obs !== held) begin
            errors++;
            $display("FAIL hold_stable[%0d]: got %h want %h", c, obs, held);
         end
      end
`ifdef WB_PERF_EN
      checks++;
      if (perf_hold_cnt !== 32'd5 || perf_bubble_cnt !== 32'd1) begin
         errors++;
         $display("FAIL perf_counts: got hold=%0d bubble=%0d want 5/1", perf_hold_cnt, perf_bubble_cnt);
      end
`endif
   endtask

   task automatic test_gpr_conflict();
      stall = 6'b000000;
      set_lanes(5'd7, 5'd7, 32'hAAAA_0001, 32'hBBBB_0002);
      tick();
      checks++;
      if (wb_wreg !== 2'b10 || wb_wdata[31:0] !== 32'hAAAA_0001 || wb_wd !== {5'd7, 5'd7}) begin
         errors++;
         $display("FAIL gpr_conflict: got wreg=%b wdata0=%h wd=%h want 10/aaaa0001/0e7",
                  wb_wreg, wb_wdata[31:0], wb_wd);
      end
      set_lanes(5'd0, 5'd0, 32'h3333_0003, 32'h4444_0004);
      tick();
      checks++;
      if (wb_wreg !== 2'b00 || wb_wdata !== {32'h4444_0004, 32'h3333_0003}) begin
         errors++;
         $display("FAIL gpr_zero_reg: got wreg=%b wdata=%h want 00/4444000433330003", wb_wreg, wb_wdata);
      end
      checks++;
      if (obs !== exp_bus()) begin
         errors++;
         $display("FAIL gpr_zero_model: got %h want %h", obs, exp_bus());
      end
   endtask

   task automatic test_hilo_conflict();
      logic [AW+1+3*DW:0] lane1;
      stall = 6'b000000;
      set_lanes(5'd1, 5'd2, 32'h5555_5555, 32'h6666_6666);
      mem_whilo = 2'b11;
      tick();
      checks++;
      if (wb_whilo !== 2'b10 || wb_hi[31:0] !== 32'hAAAA_AAAA) begin
         errors++;
         $display("FAIL hilo_conflict: got whilo=%b hi0=%h want 10/aaaaaaaa", wb_whilo, wb_hi[31:0]);
      end
      mem_valid = 2'b01;
      tick();
      lane1 = {wb_wd[2*AW-1:AW], wb_wreg[1], wb_wdata[63:32], wb_hi[63:32], wb_lo[63:32], wb_whilo[1]};
      checks++;
      if (lane1 !== '0 || wb_whilo[0] !== 1'b1) begin
         errors++;
         $display("FAIL invalid_lane: got lane1=%h whilo0=%b want 0/1", lane1, wb_whilo[0]);
      end
   endtask

   task automatic test_flush_vs_stall();
      stall = 6'b000000;
      set_lanes(5'd12, 5'd13, 32'h7777_7777, 32'h8888_8888);
      tick();
      flush = 1'b1;
      stall = 6'b110000;
      tick();
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL flush_over_stall: got %h want 0", obs);
      end
      flush = 1'b0;
      rand_inputs(31);
      tick();
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL hold_after_flush: got %h want 0", obs);
      end
`ifdef WB_PERF_EN
      checks++;
      if (perf_hold_cnt !== m_hold || perf_bubble_cnt !== m_bubble) begin
         errors++;
         $display("FAIL flush_perf: got hold=%0d bubble=%0d want %0d/%0d",
                  perf_hold_cnt, perf_bubble_cnt, m_hold, m_bubble);
      end
`endif
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rand_inputs(7);
         stall = SW'($urandom);
         flush = ($urandom_range(15, 0) == 0);
         rst   = ($urandom_range(63, 0) == 0);
         tick();
         checks++;
         if (obs !== exp_bus()) begin
            errors++;
            $display("FAIL random[%0d]: got %h want %h", c, obs, exp_bus());
         end
`ifdef WB_PERF_EN
         checks++;
         if (perf_hold_cnt !== m_hold || perf_bubble_cnt !== m_bubble) begin
            errors++;
            $display("FAIL random_perf[%0d]: got hold=%0d bubble=%0d want %0d/%0d",
                     c, perf_hold_cnt, perf_bubble_cnt, m_hold, m_bubble);
         end
`endif
      end
      rst   = 1'b0;
      flush = 1'b0;
   endtask

`ifdef WB_PERF_EN
   task automatic test_saturation();
      rst   = 1'b0;
      flush = 1'b0;
      stall = 6'b010000;
      force dut.bubble_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.bubble_cnt_q;
      m_bubble = 32'hFFFF_FFFE;
      for (int c = 0; c < 3; c++) tick();
      checks++;
      if (perf_bubble_cnt !== 32'hFFFF_FFFF || m_bubble !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL bubble_saturate: got %h want ffffffff", perf_bubble_cnt);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (perf_bubble_cnt !== 32'd0 || perf_hold_cnt !== 32'd0) begin
         errors++;
         $display("FAIL perf_rst_clear: got bubble=%h hold=%h want 0/0", perf_bubble_cnt, perf_hold_cnt);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      stall     = '0;
      mem_valid = '0;
      mem_wd    = '0;
      mem_wreg  = '0;
      mem_wdata = '0;
      mem_hi    = '0;
      mem_lo    = '0;
      mem_whilo = '0;
      for (int i = 0; i < L; i++) m[i] = '0;
      #2;
      test_reset();
      test_advance_bubble_hold();
      test_gpr_conflict();
      test_hilo_conflict();
      test_flush_vs_stall();
      test_random();
`ifdef WB_PERF_EN
      test_saturation();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
